// File: rtl/i2c_master_burst.sv
// I2C master for EEPROM-class slaves: runtime device/memory address, page-write and
// sequential-read bursts, open-drain SDA, NACK abort. All timing derives from a quarter-bit tick.
module i2c_master_burst #(
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned SCL_FREQ     = 250_000,
  parameter int unsigned MAX_LEN      = 32,
  localparam int unsigned LEN_W       = $clog2(MAX_LEN)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       dev_addr,
  input  logic             addr_num,
  input  logic [15:0]      byte_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  output logic             wr_req,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  output logic             scl,
  inout  wire              sda
);

  localparam int unsigned CNT_QTR = SYS_CLK_FREQ / (SCL_FREQ * 4);
  localparam int unsigned CNT_W   = (CNT_QTR > 1) ? $clog2(CNT_QTR) : 1;

  // Each byte-send state is immediately followed by its ACK slot in this encoding.
  typedef enum logic [3:0] {
    StIdle, StStart, StDevW, StAckDw, StAddrH, StAckAh, StAddrL, StAckAl,
    StWrByte, StAckWr, StRstart, StDevR, StAckDr, StRdByte, StMAck, StStop
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       q_q, q_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_q, rx_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic             rw_q, rw_d;
  logic [6:0]       dev_q, dev_d;
  logic             addr_num_q, addr_num_d;
  logic [15:0]      addr_q, addr_d;
  logic             nack_q, nack_d;
  logic             ack_err_q, ack_err_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             scl_q, scl_d;
  logic             sda_low_q, sda_low_d;
  logic             wr_take;
  logic             tick, sample, slot_end;
  logic             sda_in;

  assign sda_in   = sda;
  assign tick     = (state_q != StIdle) && (cnt_q == CNT_W'(CNT_QTR - 1));
  assign sample   = tick && (q_q == 2'd1);
  assign slot_end = tick && (q_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    left_d     = left_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    addr_num_d = addr_num_q;
    addr_d     = addr_q;
    nack_d     = nack_q;
    ack_err_d  = ack_err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    wr_take    = 1'b0;

    if (state_q == StIdle) begin
      cnt_d = '0;
      q_d   = 2'd0;
      if (start) begin
        rw_d       = rw;
        dev_d      = dev_addr;
        addr_num_d = addr_num;
        addr_d     = byte_addr;
        left_d     = len;
        ack_err_d  = 1'b0;
        bit_d      = '0;
        state_d    = StStart;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) q_d = q_q + 2'd1;
      if (sample) begin
        nack_d = sda_in;
        if (state_q == StRdByte) rx_d = {rx_q[6:0], sda_in};
      end
      if (slot_end) begin
        unique case (state_q)
          StStart: begin
            state_d = StDevW;
            sh_d    = {dev_q, 1'b0};
          end
          StRstart: begin
            state_d = StDevR;
            sh_d    = {dev_q, 1'b1};
          end
          StDevW, StAddrH, StAddrL, StWrByte, StDevR: begin
            if (bit_q == 3'd7) begin
              bit_d   = '0;
              state_d = state_e'(state_q + 4'd1);
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
          StRdByte: begin
            if (bit_q == 3'd7) begin
              bit_d      = '0;
              state_d    = StMAck;
              rd_data_d  = rx_q;
              rd_valid_d = 1'b1;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          StAckDw, StAckAh, StAckAl, StAckWr, StAckDr: begin
            if (nack_q) begin
              ack_err_d = 1'b1;
              state_d   = StStop;
            end else begin
              unique case (state_q)
                StAckDw: begin
                  state_d = addr_num_q ? StAddrH : StAddrL;
                  sh_d    = addr_num_q ? addr_q[15:8] : addr_q[7:0];
                end
                StAckAh: begin
                  state_d = StAddrL;
                  sh_d    = addr_q[7:0];
                end
                StAckAl: begin
                  if (rw_q) begin
                    state_d = StRstart;
                  end else begin
                    state_d = StWrByte;
                    sh_d    = wr_data;
                    wr_take = 1'b1;
                  end
                end
                StAckWr: begin
                  if (left_q == '0) begin
                    state_d = StStop;
                  end else begin
                    left_d  = left_q - 1'b1;
                    state_d = StWrByte;
                    sh_d    = wr_data;
                    wr_take = 1'b1;
                  end
                end
                default: state_d = StRdByte;
              endcase
            end
          end
          StMAck: begin
            if (left_q == '0) begin
              state_d = StStop;
            end else begin
              left_d  = left_q - 1'b1;
              state_d = StRdByte;
            end
          end
          StStop: begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // Pin levels follow the next state and quarter so they are registered in step.
    busy_d    = (state_d != StIdle);
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    unique case (state_d)
      StIdle:   scl_d = 1'b1;
      StStart: begin
        scl_d     = (q_d != 2'd3);
        sda_low_d = q_d[1];
      end
      StRstart: begin
        scl_d     = ^q_d;
        sda_low_d = q_d[1];
      end
      StStop: begin
        scl_d     = (q_d != 2'd0);
        sda_low_d = ~q_d[1];
      end
      StDevW, StAddrH, StAddrL, StWrByte, StDevR: begin
        scl_d     = ^q_d;
        sda_low_d = ~sh_d[7];
      end
      StMAck: begin
        scl_d     = ^q_d;
        sda_low_d = (left_d != '0);
      end
      default:  scl_d = ^q_d;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      q_q        <= 2'd0;
      bit_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      left_q     <= '0;
      rw_q       <= 1'b0;
      dev_q      <= '0;
      addr_num_q <= 1'b0;
      addr_q     <= '0;
      nack_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      left_q     <= left_d;
      rw_q       <= rw_d;
      dev_q      <= dev_d;
      addr_num_q <= addr_num_d;
      addr_q     <= addr_d;
      nack_q     <= nack_d;
      ack_err_q  <= ack_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      scl_q      <= scl_d;
      sda_low_q  <= sda_low_d;
    end
  end

  assign wr_req   = wr_take;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign scl      = scl_q;
  assign sda      = sda_low_q ? 1'b0 : 1'bz;

endmodule
